// File: rtl/soda_coin_feeder_pkg.sv
// Shared definitions for the soda coin feeder and its machine-side model.
// Holds the feeder states and the coin/price constants.
package soda_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COIN,
        WAIT,
        DONE
    } state_t;

    localparam int VAL1  = 1;
    localparam int VAL5  = 5;
    localparam int VAL10 = 10;
    localparam int PRICE = 3;

endpackage

// File: rtl/soda_change_counter.sv
// Saturating accumulator for the bottle and change tallies.
// Clears on reset or clr; adds 'add' when en is high, sticking at all-ones.
module soda_change_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] add,
    output logic [W-1:0] total
);

    logic [W:0] sum;

    assign sum = {1'b0, total} + {1'b0, add};

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            total <= '0;
        end else if (en) begin
            total <= sum[W] ? '1 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/soda_coin_feeder.sv
// Customer-side coin feeder: spends the purse largest coin first and
// tallies bottles and change returned by the vending machine.
module soda_coin_feeder
    import soda_pkg::*;
#(
    parameter int CNT_W    = 4,
    parameter int SUM_W    = 8,
    parameter int QUIET    = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n1,
    input  logic [CNT_W-1:0] n5,
    input  logic [CNT_W-1:0] n10,
    output logic             B1,
    output logic             B5,
    output logic             B10,
    input  logic             bottle_in,
    input  logic             R1_in,
    input  logic             R5_in,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] bottles,
    output logic [SUM_W-1:0] change_total,
    output logic [SUM_W-1:0] paid_total
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    state_t           state;
    logic [CNT_W-1:0] p1, p5, p10;
    logic [2:0]       quiet;
    logic [WW-1:0]    wcnt;

    logic             idle_go;
    logic [CNT_W-1:0] s1, s5, s10;
    logic             any;
    logic             sel1, sel5, sel10;
    logic [3:0]       cval;
    logic             quiet_hit;
    logic             wait_hit;
    logic             go_coin;
    logic [SUM_W-1:0] paid_base;
    logic [SUM_W:0]   paid_sum;

    logic             tally_en;
    logic [SUM_W-1:0] chg_add;
    logic [CNT_W-1:0] btl_add;

    assign idle_go = (state == IDLE) && start;

    // In IDLE the next coin comes from the inputs, later from the purse.
    always_comb begin
        s1  = p1;
        s5  = p5;
        s10 = p10;
        if (idle_go) begin
            s1  = n1;
            s5  = n5;
            s10 = n10;
        end
    end

    assign any   = |{s1, s5, s10};
    assign sel10 = |s10;
    assign sel5  = !sel10 && |s5;
    assign sel1  = !sel10 && !sel5 && |s1;

    always_comb begin
        cval = 4'(VAL1);
        unique case (1'b1)
            sel10:   cval = 4'(VAL10);
            sel5:    cval = 4'(VAL5);
            default: cval = 4'(VAL1);
        endcase
    end

    assign quiet_hit = !R1_in && (quiet + 3'd1 == 3'(QUIET));
    assign wait_hit  = (wcnt + WW'(1) == WW'(MAX_WAIT));

    assign go_coin = (idle_go && any)
                   || ((state == WAIT) && quiet_hit && any);

    assign paid_base = idle_go ? '0 : paid_total;
    assign paid_sum  = {1'b0, paid_base} + (SUM_W + 1)'(cval);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            B1         <= 1'b0;
            B5         <= 1'b0;
            B10        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            p1         <= '0;
            p5         <= '0;
            p10        <= '0;
            quiet      <= '0;
            wcnt       <= '0;
            paid_total <= '0;
        end else begin
            B1   <= 1'b0;
            B5   <= 1'b0;
            B10  <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        error      <= 1'b0;
                        paid_total <= '0;
                        quiet      <= '0;
                        wcnt       <= '0;
                        p1         <= '0;
                        p5         <= '0;
                        p10        <= '0;
                        if (any) begin
                            state <= COIN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                COIN: begin
                    state <= WAIT;
                    quiet <= '0;
                    wcnt  <= '0;
                end
                WAIT: begin
                    quiet <= R1_in ? 3'd0 : quiet + 3'd1;
                    wcnt  <= wcnt + WW'(1);
                    if (quiet_hit) begin
                        if (any) begin
                            state <= COIN;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else if (wait_hit) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        error <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Coin issue shares one path for the first and later coins.
            if (go_coin) begin
                B1         <= sel1;
                B5         <= sel5;
                B10        <= sel10;
                p1         <= s1 - CNT_W'(sel1);
                p5         <= s5 - CNT_W'(sel5);
                p10        <= s10 - CNT_W'(sel10);
                paid_total <= paid_sum[SUM_W] ? '1 : paid_sum[SUM_W-1:0];
            end
        end
    end

    assign tally_en = (state == COIN) || (state == WAIT);
    assign chg_add  = SUM_W'(R1_in) + (R5_in ? SUM_W'(VAL5) : '0);
    assign btl_add  = CNT_W'(bottle_in);

    soda_change_counter #(
        .W(SUM_W)
    ) u_change (
        .clk   (clk),
        .reset (reset),
        .clr   (idle_go),
        .en    (tally_en),
        .add   (chg_add),
        .total (change_total)
    );

    soda_change_counter #(
        .W(CNT_W)
    ) u_bottles (
        .clk   (clk),
        .reset (reset),
        .clr   (idle_go),
        .en    (tally_en),
        .add   (btl_add),
        .total (bottles)
    );

endmodule

// File: tb/tb_soda_coin_feeder.sv
// Directed bench for soda_coin_feeder with a small vending machine stub.
// Stub: price 3, bottle/R5 same cycle as the coin, R1 pulses afterwards.
module tb_soda_coin_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] n1, n5, n10;
    logic       B1, B5, B10;
    logic       bottle_in, R1_in, R5_in;
    logic       busy, done, error;
    logic [3:0] bottles;
    logic [7:0] change_total, paid_total;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    soda_coin_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .n1           (n1),
        .n5           (n5),
        .n10          (n10),
        .B1           (B1),
        .B5           (B5),
        .B10          (B10),
        .bottle_in    (bottle_in),
        .R1_in        (R1_in),
        .R5_in        (R5_in),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bottles      (bottles),
        .change_total (change_total),
        .paid_total   (paid_total)
    );

    // Machine stub
    logic       stuck;
    logic       armed;
    logic [4:0] credit;
    logic [3:0] r1p;
    logic [4:0] cv;
    logic [4:0] sum;

    always_comb begin
        cv        = B10 ? 5'd10 : B5 ? 5'd5 : B1 ? 5'd1 : 5'd0;
        sum       = credit + cv;
        bottle_in = (cv != 5'd0) && (sum >= 5'd3);
        R5_in     = bottle_in && (sum >= 5'd8);
        R1_in     = (r1p != 4'd0) || (stuck && armed);
    end

    always @(posedge clk) begin
        if (reset) begin
            credit <= '0;
            r1p    <= '0;
            armed  <= 1'b0;
        end else begin
            if (cv != 5'd0) begin
                if (bottle_in) begin
                    credit <= '0;
                    r1p    <= R5_in ? 4'(sum - 5'd8) : 4'(sum - 5'd3);
                end else begin
                    credit <= sum;
                end
                if (stuck) armed <= 1'b1;
            end else if (r1p != 4'd0) begin
                r1p <= r1p - 4'd1;
            end
            if (!stuck) armed <= 1'b0;
        end
    end

    // Coin pulse monitor
    int  nb1 = 0, nb5 = 0, nb10 = 0;
    int  nmulti = 0, nr1ov = 0, nlong = 0;
    logic prev_coin = 1'b0;

    always @(negedge clk) begin
        if (B1) nb1++;
        if (B5) nb5++;
        if (B10) nb10++;
        if (int'(B1) + int'(B5) + int'(B10) > 1) nmulti++;
        if (R1_in && (B1 || B5 || B10)) nr1ov++;
        if (prev_coin && (B1 || B5 || B10)) nlong++;
        prev_coin = B1 || B5 || B10;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic kick(input logic [3:0] a1, input logic [3:0] a5,
                        input logic [3:0] a10);
        @(posedge clk) #1;
        n1    = a1;
        n5    = a5;
        n10   = a10;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk) #1;
            cyc++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk) #1;
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
    endtask

    int c;
    int b1s, b5s, b10s;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stuck = 1'b0;
        n1    = '0;
        n5    = '0;
        n10   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_coins", int'({B1, B5, B10}), 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_bottles", bottles, 0);
        check("rst_change", change_total, 0);
        check("rst_paid", paid_total, 0);
        reset = 1'b0;

        // One ten: bottle + R5 on the coin, then two R1 pulses
        b10s = nb10;
        kick(4'd0, 4'd0, 4'd1);
        check("t1_first_b10", B10, 1);
        check("t1_busy", busy, 1);
        wait_done(c);
        check("t1_latency", c, 5);
        check("t1_bottles", bottles, 1);
        check("t1_change", change_total, 7);
        check("t1_paid", paid_total, 10);
        check("t1_error", error, 0);
        check("t1_busy_done", busy, 0);
        check("t1_n10", nb10 - b10s, 1);
        @(posedge clk) #1;
        check("t1_done_1cyc", done, 0);
        check("t1_hold_change", change_total, 7);
        do_reset();

        // Three ones: bottle only on the third
        b1s = nb1;
        kick(4'd3, 4'd0, 4'd0);
        wait_done(c);
        check("t2_latency", c, 7);
        check("t2_n1", nb1 - b1s, 3);
        check("t2_bottles", bottles, 1);
        check("t2_change", change_total, 0);
        check("t2_paid", paid_total, 3);
        do_reset();

        // Five then one: change 2 delays the one
        b1s = nb1;
        b5s = nb5;
        kick(4'd1, 4'd1, 4'd0);
        check("t3_first_b5", B5, 1);
        wait_done(c);
        check("t3_latency", c, 7);
        check("t3_n5", nb5 - b5s, 1);
        check("t3_n1", nb1 - b1s, 1);
        check("t3_bottles", bottles, 1);
        check("t3_change", change_total, 2);
        check("t3_paid", paid_total, 6);
        do_reset();

        // Empty purse
        b1s = nb1 + nb5 + nb10;
        kick(4'd0, 4'd0, 4'd0);
        check("t4_done_lat", done, 1);
        check("t4_bottles", bottles, 0);
        check("t4_change", change_total, 0);
        check("t4_paid", paid_total, 0);
        check("t4_coins", nb1 + nb5 + nb10 - b1s, 0);
        do_reset();

        // Stuck change stream
        stuck = 1'b1;
        b1s = nb1;
        kick(4'd2, 4'd0, 4'd0);
        wait_done(c);
        check("t5_latency", c, 17);
        check("t5_error", error, 1);
        check("t5_change", change_total, 15);
        check("t5_paid", paid_total, 1);
        check("t5_n1", nb1 - b1s, 1);
        stuck = 1'b0;
        @(posedge clk) #1;
        check("t5_error_held", error, 1);
        kick(4'd0, 4'd0, 4'd0);
        check("t5_error_clr", error, 0);
        do_reset();

        // Reset during the second WAIT cycle
        kick(4'd0, 4'd0, 4'd1);
        @(posedge clk) #1;
        @(posedge clk) #1;
        check("t6_busy_pre", busy, 1);
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        check("t6_coins", int'({B1, B5, B10}), 0);
        check("t6_busy", busy, 0);
        check("t6_change", change_total, 0);
        check("t6_paid", paid_total, 0);
        check("t6_bottles", bottles, 0);
        b1s = nb1;
        kick(4'd3, 4'd0, 4'd0);
        wait_done(c);
        check("t6_latency", c, 7);
        check("t6_n1", nb1 - b1s, 3);
        check("t6_bottles2", bottles, 1);
        check("t6_paid2", paid_total, 3);
        check("t6_error", error, 0);

        check("coin_exclusive", nmulti, 0);
        check("coin_vs_r1", nr1ov, 0);
        check("coin_one_cycle", nlong, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
